// File: rtl/axi_video_test_pattern.sv
// AXI4-Stream synthetic video source: colour bars, ramp, checkerboard or solid colour.
// TUSER marks pixel (0,0) and TLAST marks end of line; frames are never truncated.
module axi_video_test_pattern #(
  parameter int DATA_W         = 24,
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int V_BLANK_CYCLES = 16,
  parameter int CHK_LOG2       = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  enable_i,
  input  logic [1:0]            pattern_sel_i,
  input  logic [23:0]           solid_rgb_i,
  output logic [DATA_W-1:0]     axi_video_tdata_o,
  output logic [DATA_W/8-1:0]   axi_video_tkeep_o,
  output logic                  axi_video_tuser_o,
  output logic                  axi_video_tlast_o,
  output logic                  axi_video_tvalid_o,
  input  logic                  axi_video_tready_i,
  output logic                  busy_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int BKW   = (V_BLANK_CYCLES > 1) ? $clog2(V_BLANK_CYCLES) : 1;

  localparam logic [XW-1:0]  X_LAST     = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_LAST     = YW'(V_ACTIVE - 1);
  localparam logic [BCW-1:0] BAR_LAST   = BCW'(BAR_W - 1);
  localparam logic [BKW-1:0] BLANK_LAST = BKW'((V_BLANK_CYCLES > 0) ? V_BLANK_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_BLANK  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [BCW-1:0]    barCnt_q, barCnt_d;
  logic [2:0]        barIdx_q, barIdx_d;
  logic [BKW-1:0]    blank_q, blank_d;
  logic [1:0]        pat_q, pat_d;
  logic [23:0]       solid_q, solid_d;
  logic [15:0]       frameCnt_q, frameCnt_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tuser_q, tuser_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic              busy_q;
  logic              handshake;
  logic              startFrame;
  logic [23:0]       pix;
  logic [7:0]        ramp;
  logic              chkBit;

  assign handshake = tvalid_q & axi_video_tready_i;

  // Coordinates always describe the pixel currently presented; they only move on a handshake.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    barCnt_d   = barCnt_q;
    barIdx_d   = barIdx_q;
    blank_d    = blank_q;
    pat_d      = pat_q;
    solid_d    = solid_q;
    frameCnt_d = frameCnt_q;
    tvalid_d   = tvalid_q;
    startFrame = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i) startFrame = 1'b1;
      end
      S_ACTIVE: begin
        if (handshake) begin
          if (x_q == X_LAST) begin
            x_d      = '0;
            barCnt_d = '0;
            barIdx_d = '0;
            if (y_q == Y_LAST) begin
              y_d        = '0;
              frameCnt_d = frameCnt_q + 16'd1;
              if (V_BLANK_CYCLES > 0) begin
                state_d  = S_BLANK;
                blank_d  = '0;
                tvalid_d = 1'b0;
              end else if (enable_i) begin
                startFrame = 1'b1;
              end else begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
              end
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
            if (barCnt_q == BAR_LAST) begin
              barCnt_d = '0;
              barIdx_d = barIdx_q + 3'd1;
            end else begin
              barCnt_d = barCnt_q + 1'b1;
            end
          end
        end
      end
      S_BLANK: begin
        if (blank_q == BLANK_LAST) begin
          if (enable_i) startFrame = 1'b1;
          else          state_d    = S_IDLE;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (startFrame) begin
      state_d  = S_ACTIVE;
      x_d      = '0;
      y_d      = '0;
      barCnt_d = '0;
      barIdx_d = '0;
      pat_d    = pattern_sel_i;
      solid_d  = solid_rgb_i;
      tvalid_d = 1'b1;
    end
  end

  // Pixel for the next presented coordinate; recomputes to the same value while stalled.
  always_comb begin
    ramp   = 8'(x_d);
    chkBit = (|((x_d >> CHK_LOG2) & XW'(1))) ^ (|((y_d >> CHK_LOG2) & YW'(1)));
    pix    = 24'h000000;
    case (pat_d)
      2'd0: begin
        case (barIdx_d)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFFFF00;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      2'd1:    pix = {ramp, ramp, ramp};
      2'd2:    pix = chkBit ? 24'hFFFFFF : 24'h000000;
      default: pix = solid_d;
    endcase
    tdata_d = tdata_q;
    tuser_d = 1'b0;
    tlast_d = 1'b0;
    if (state_d == S_ACTIVE) begin
      tdata_d = DATA_W'(pix);
      tuser_d = (x_d == '0) && (y_d == '0);
      tlast_d = (x_d == X_LAST);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      barCnt_q   <= '0;
      barIdx_q   <= '0;
      blank_q    <= '0;
      pat_q      <= '0;
      solid_q    <= '0;
      frameCnt_q <= '0;
      tdata_q    <= '0;
      tuser_q    <= 1'b0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      barCnt_q   <= barCnt_d;
      barIdx_q   <= barIdx_d;
      blank_q    <= blank_d;
      pat_q      <= pat_d;
      solid_q    <= solid_d;
      frameCnt_q <= frameCnt_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign axi_video_tdata_o  = tdata_q;
  assign axi_video_tkeep_o  = '1;
  assign axi_video_tuser_o  = tuser_q;
  assign axi_video_tlast_o  = tlast_q;
  assign axi_video_tvalid_o = tvalid_q;
  assign busy_o             = busy_q;
  assign frame_cnt_o        = frameCnt_q;

endmodule
